// File: rtl/btn_debounce_events.sv
// Push-button conditioner: 2-FF synchroniser, per-bit debounce FSM, press/release pulses, sticky pending flags.
// Optional level interrupt with per-button mask when BTN_IRQ_EN is defined.
module btn_debounce_events #(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btns_i,
    output logic [N_BTN-1:0] btns_o,
    output logic [N_BTN-1:0] press_o,
    output logic [N_BTN-1:0] release_o,
    output logic [N_BTN-1:0] press_pend,
    output logic [N_BTN-1:0] rel_pend,
    input  logic [N_BTN-1:0] clr_press,
    input  logic [N_BTN-1:0] clr_rel
`ifdef BTN_IRQ_EN
    ,
    input  logic [N_BTN-1:0] irq_mask,
    output logic             irq
`endif
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } state_t;

    logic [N_BTN-1:0] sync1_r;
    logic [N_BTN-1:0] sync2_r;
    logic [N_BTN-1:0] level_r;
    logic [N_BTN-1:0] press_r;
    logic [N_BTN-1:0] release_r;
    logic [N_BTN-1:0] press_pend_r;
    logic [N_BTN-1:0] rel_pend_r;
    logic [N_BTN-1:0] flip_s;
    state_t           state_r     [N_BTN];
    state_t           state_nxt_s [N_BTN];
    logic [CW-1:0]    cnt_r       [N_BTN];
    logic [CW-1:0]    cnt_nxt_s   [N_BTN];

    // Two-stage synchroniser; polarity is normalised before the first stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= {N_BTN{1'b0}};
            sync2_r <= {N_BTN{1'b0}};
        end else begin
            sync1_r <= btns_i ^ {N_BTN{ACTIVE_LOW}};
            sync2_r <= sync1_r;
        end
    end

    // Debounce FSM state and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_BTN; i++) begin
                state_r[i] <= ST_STABLE;
                cnt_r[i]   <= {CW{1'b0}};
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                state_r[i] <= state_nxt_s[i];
                cnt_r[i]   <= cnt_nxt_s[i];
            end
        end
    end

    // Next-state logic: the count tracks consecutive samples disagreeing with the accepted level.
    always_comb begin
        flip_s = {N_BTN{1'b0}};
        for (int i = 0; i < N_BTN; i++) begin
            state_nxt_s[i] = state_r[i];
            cnt_nxt_s[i]   = cnt_r[i];
            case (state_r[i])
                ST_STABLE: begin
                    if (sync2_r[i] != level_r[i]) begin
                        state_nxt_s[i] = ST_CHECK;
                        cnt_nxt_s[i]   = CW'(1);
                    end else begin
                        state_nxt_s[i] = ST_STABLE;
                        cnt_nxt_s[i]   = {CW{1'b0}};
                    end
                end
                ST_CHECK: begin
                    if (sync2_r[i] == level_r[i]) begin
                        state_nxt_s[i] = ST_STABLE;
                        cnt_nxt_s[i]   = {CW{1'b0}};
                    end else if (cnt_r[i] == CNT_MAX) begin
                        flip_s[i]      = 1'b1;
                        state_nxt_s[i] = ST_STABLE;
                        cnt_nxt_s[i]   = {CW{1'b0}};
                    end else begin
                        state_nxt_s[i] = ST_CHECK;
                        cnt_nxt_s[i]   = cnt_r[i] + CW'(1);
                    end
                end
                default: begin
                    state_nxt_s[i] = ST_STABLE;
                    cnt_nxt_s[i]   = {CW{1'b0}};
                end
            endcase
        end
    end

    // Accepted level, edge pulses and sticky flags; a set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_r      <= {N_BTN{1'b0}};
            press_r      <= {N_BTN{1'b0}};
            release_r    <= {N_BTN{1'b0}};
            press_pend_r <= {N_BTN{1'b0}};
            rel_pend_r   <= {N_BTN{1'b0}};
        end else begin
            level_r      <= level_r ^ flip_s;
            press_r      <= flip_s & ~level_r;
            release_r    <= flip_s & level_r;
            press_pend_r <= (press_pend_r & ~clr_press) | press_r;
            rel_pend_r   <= (rel_pend_r & ~clr_rel) | release_r;
        end
    end

    assign btns_o     = level_r;
    assign press_o    = press_r;
    assign release_o  = release_r;
    assign press_pend = press_pend_r;
    assign rel_pend   = rel_pend_r;

`ifdef BTN_IRQ_EN
    logic irq_r;

    // Registered level interrupt over the masked pending flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= |((press_pend_r | rel_pend_r) & irq_mask);
        end
    end

    assign irq = irq_r;
`endif

endmodule

// File: tb/tb_btn_debounce_events.sv
// Scoreboard bench for btn_debounce_events: a reference model predicts every output per cycle,
// a monitor pops predictions on the falling edge and compares them with the DUT.
module tb_btn_debounce_events;

    localparam int NB = 2;
    localparam int DC = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btns_i = '0;
    logic [NB-1:0] clr_press = '0;
    logic [NB-1:0] clr_rel = '0;
    logic [NB-1:0] btns_o, press_o, release_o, press_pend, rel_pend;
`ifdef BTN_IRQ_EN
    logic [NB-1:0] irq_mask = '0;
    logic          irq;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [NB-1:0] lvl;
        logic [NB-1:0] pr;
        logic [NB-1:0] rl;
        logic [NB-1:0] pp;
        logic [NB-1:0] rp;
        logic          irq;
    } exp_t;

    exp_t sb_q[$];

    btn_debounce_events #(.N_BTN(NB), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1'b0)) dut (
        .clk        (clk),
        .rst        (rst),
        .btns_i     (btns_i),
        .btns_o     (btns_o),
        .press_o    (press_o),
        .release_o  (release_o),
        .press_pend (press_pend),
        .rel_pend   (rel_pend),
        .clr_press  (clr_press),
        .clr_rel    (clr_rel)
`ifdef BTN_IRQ_EN
        ,
        .irq_mask   (irq_mask),
        .irq        (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a button's level is accepted after DC consecutive synchronised
    // samples disagree with the current level; samples reach the filter two edges late.
    initial begin : model
        logic [NB-1:0] s1, s2, lvl, pr, rl, pp, rp, flip;
        logic          mirq;
        int            run[NB];
        exp_t          e;
        s1 = '0; s2 = '0; lvl = '0; pr = '0; rl = '0; pp = '0; rp = '0; mirq = 1'b0;
        for (int i = 0; i < NB; i++) run[i] = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                s1 = '0; s2 = '0; lvl = '0; pr = '0; rl = '0; pp = '0; rp = '0; mirq = 1'b0;
                for (int i = 0; i < NB; i++) run[i] = 0;
            end else begin
`ifdef BTN_IRQ_EN
                mirq = |((pp | rp) & irq_mask);
`endif
                pp = (pp & ~clr_press) | pr;
                rp = (rp & ~clr_rel) | rl;
                flip = '0;
                for (int i = 0; i < NB; i++) begin
                    run[i] = (s2[i] != lvl[i]) ? run[i] + 1 : 0;
                    if (run[i] == DC) begin
                        flip[i] = 1'b1;
                        run[i]  = 0;
                    end
                end
                pr  = flip & ~lvl;
                rl  = flip & lvl;
                lvl = lvl ^ flip;
                s2  = s1;
                s1  = btns_i;
            end
            e.lvl = lvl; e.pr = pr; e.rl = rl; e.pp = pp; e.rp = rp; e.irq = mirq;
            sb_q.push_back(e);
        end
    end

    // Monitor: compare each predicted cycle against what the DUT presents.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("btns_o",     32'(btns_o),     32'(e.lvl));
                check("press_o",    32'(press_o),    32'(e.pr));
                check("release_o",  32'(release_o),  32'(e.rl));
                check("press_pend", 32'(press_pend), 32'(e.pp));
                check("rel_pend",   32'(rel_pend),   32'(e.rp));
`ifdef BTN_IRQ_EN
                check("irq",        32'(irq),        32'(e.irq));
`endif
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr(input logic [NB-1:0] cp, input logic [NB-1:0] cr);
        clr_press = cp;
        clr_rel   = cr;
        cyc(1);
        clr_press = '0;
        clr_rel   = '0;
    endtask

    int press_seen = 0;
    // Count DUT press pulses on bit 0 during the bounce phase (extra directed check).
    initial begin : press_counter
        forever begin
            @(negedge clk);
            if (press_o[0]) press_seen++;
        end
    end

    initial begin : stim
        cyc(3);
        rst = 1'b0;
        cyc(2);

        // clean press on bit 0
        btns_i = 2'b01;
        cyc(20);

        // glitch on bit 1: 5 cycles high is shorter than the filter
        btns_i = 2'b11;
        cyc(5);
        btns_i = 2'b01;
        cyc(15);

        // bounce on bit 0 after a clean release
        btns_i = 2'b00;
        cyc(20);
        pulse_clr(2'b11, 2'b11);
        press_seen = 0;
        for (int k = 0; k < 40; k += 3) begin
            btns_i[0] = ~btns_i[0];
            cyc(3);
        end
        btns_i = 2'b01;
        cyc(20);
        check("bounce_press_count", 32'(press_seen), 32'd1);

        // clear strobe coinciding with a fresh press pulse
        btns_i = 2'b00;
        cyc(20);
        pulse_clr(2'b11, 2'b11);
        btns_i = 2'b01;
        cyc(DC + 2);
        clr_press = 2'b01;
        cyc(1);
        clr_press = 2'b00;
        cyc(3);
        pulse_clr(2'b01, 2'b00);
        cyc(3);

        // reset in the middle of a count with the button held
        btns_i = 2'b00;
        cyc(20);
        btns_i = 2'b01;
        cyc(7);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(20);

        // interrupt masking
        btns_i = 2'b00;
        cyc(20);
        pulse_clr(2'b11, 2'b11);
`ifdef BTN_IRQ_EN
        irq_mask = 2'b01;
`endif
        cyc(2);
        btns_i = 2'b10;
        cyc(20);
        btns_i = 2'b11;
        cyc(20);
        pulse_clr(2'b01, 2'b00);
        cyc(5);

        // randomised hold lengths, clear strobes and occasional resets
        for (int seg = 0; seg < 300; seg++) begin
            btns_i = NB'($urandom);
            for (int c = 0; c < int'($urandom_range(1, 14)); c++) begin
                clr_press = ($urandom_range(0, 7) == 0) ? NB'($urandom) : '0;
                clr_rel   = ($urandom_range(0, 7) == 0) ? NB'($urandom) : '0;
`ifdef BTN_IRQ_EN
                if ($urandom_range(0, 31) == 0) irq_mask = NB'($urandom);
`endif
                rst = ($urandom_range(0, 299) == 0);
                cyc(1);
            end
        end
        rst = 1'b0;
        clr_press = '0;
        clr_rel = '0;

        repeat (3) @(posedge clk);
        #6;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
